// File: rtl/can_bit_timing.sv
// CAN bit timing: splits each bit into SYNC/TSEG1/TSEG2 time quanta, samples rx, applies hard sync and SJW-bounded resync.
// Latency: rx to internal edge detect is 2 clocks; sample_point/tx_point/resync_pulse are registered (1 clock after the deciding edge).
// Backpressure: none; free-running stage, outputs are single-clock pulses the consumer must catch.
module can_bit_timing #(
  parameter int BRP   = 1,
  parameter int TSEG1 = 3,
  parameter int TSEG2 = 2,
  parameter int SJW   = 1
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_rx,
  input  logic i_hard_sync_en,
  output logic o_rx_bit,
  output logic o_sample_point,
  output logic o_tx_point,
  output logic o_resync_pulse
);

  typedef enum logic [1:0] {
    SEG_SYNC  = 2'd0,
    SEG_TSEG1 = 2'd1,
    SEG_TSEG2 = 2'd2
  } seg_e;

  localparam logic [5:0] BRP_M1 = 6'(BRP - 1);
  localparam logic [4:0] T1_LEN = 5'(TSEG1);
  localparam logic [4:0] T2_LEN = 5'(TSEG2);
  localparam logic [4:0] SJW_W  = 5'(SJW);

  // rx synchroniser chain; r_rx_s_prev is one clock older than r_rx_s for edge detection
  logic r_rx_meta, r_rx_s, r_rx_s_prev;

  seg_e       r_seg, w_seg_nxt;
  logic [5:0] r_presc, w_presc_nxt;
  logic [4:0] r_idx, w_idx_nxt;
  logic [4:0] r_t1_len, r_t2_len;
  logic [4:0] w_t1_len_eff, w_t2_len_eff;
  logic       r_lock, w_lock_nxt;
  logic       r_rx_bit, r_sp, r_tx, r_rs;
  logic       w_sp_nxt, w_tx_nxt, w_rs_nxt;

  logic       w_tq_tick, w_edge, w_hard, w_resync;
  logic       w_t1_late, w_t2_early, w_t2_end, w_t2_shrink, w_force_sync;
  logic       w_t1_last, w_t2_last, w_enter_sync;
  logic [4:0] w_e, w_t1_adj, w_r;

  assign w_tq_tick = (r_presc == BRP_M1);
  assign w_edge    = r_rx_s_prev & ~r_rx_s;
  assign w_hard    = w_edge & i_hard_sync_en;
  assign w_resync  = w_edge & ~i_hard_sync_en & ~r_lock;

  // Late edge in TSEG1 stretches it by the phase error, capped at SJW
  assign w_t1_late    = w_resync && (r_seg == SEG_TSEG1);
  assign w_e          = r_idx + 5'd1;
  assign w_t1_adj     = (w_e < SJW_W) ? w_e : SJW_W;
  assign w_t1_len_eff = r_t1_len + (w_t1_late ? w_t1_adj : 5'd0);

  // Early edge in TSEG2: small error ends the bit now, otherwise TSEG2 shrinks by SJW
  assign w_t2_early   = w_resync && (r_seg == SEG_TSEG2);
  assign w_r          = T2_LEN - r_idx;
  assign w_t2_end     = w_t2_early && (w_r <= SJW_W);
  assign w_t2_shrink  = w_t2_early && !w_t2_end;
  assign w_t2_len_eff = r_t2_len - (w_t2_shrink ? SJW_W : 5'd0);

  assign w_force_sync = w_hard | w_t2_end;
  // Last-tq tests use the lengths already adjusted this cycle so a same-cycle resync takes effect
  assign w_t1_last    = (r_seg == SEG_TSEG1) && (r_idx == w_t1_len_eff - 5'd1);
  assign w_t2_last    = (r_seg == SEG_TSEG2) && (r_idx == w_t2_len_eff - 5'd1);
  assign w_enter_sync = w_force_sync | (w_tq_tick & w_t2_last);

  // Two-flop synchroniser plus history flop; idle bus is recessive
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_rx_meta   <= 1'b1;
      r_rx_s      <= 1'b1;
      r_rx_s_prev <= 1'b1;
    end else begin
      r_rx_meta   <= i_rx;
      r_rx_s      <= r_rx_meta;
      r_rx_s_prev <= r_rx_s;
    end
  end

  // Segment state register
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_seg <= SEG_SYNC;
    end else begin
      r_seg <= w_seg_nxt;
    end
  end

  // Next segment: syncs force SYNC, otherwise advance on tq boundaries
  always_comb begin
    w_seg_nxt = r_seg;
    if (w_force_sync) begin
      w_seg_nxt = SEG_SYNC;
    end else if (w_tq_tick) begin
      case (r_seg)
        SEG_SYNC:  w_seg_nxt = SEG_TSEG1;
        SEG_TSEG1: w_seg_nxt = w_t1_last ? SEG_TSEG2 : SEG_TSEG1;
        SEG_TSEG2: w_seg_nxt = w_t2_last ? SEG_SYNC : SEG_TSEG2;
        default:   w_seg_nxt = SEG_SYNC;
      endcase
    end
  end

  // Counters, lock and pulse decode for the next cycle
  always_comb begin
    w_presc_nxt = r_presc + 6'd1;
    w_idx_nxt   = r_idx;
    w_lock_nxt  = r_lock;
    w_sp_nxt    = w_tq_tick & w_t1_last & ~w_force_sync;
    w_tx_nxt    = w_enter_sync;
    w_rs_nxt    = w_hard | (w_resync & (r_seg != SEG_SYNC));
    if (w_force_sync || w_tq_tick) begin
      w_presc_nxt = 6'd0;
    end
    if (w_force_sync || (w_tq_tick && (w_seg_nxt != r_seg))) begin
      w_idx_nxt = 5'd0;
    end else if (w_tq_tick) begin
      w_idx_nxt = r_idx + 5'd1;
    end
    // Setting the lock wins over the sample-point clear
    if (w_rs_nxt) begin
      w_lock_nxt = 1'b1;
    end else if (w_sp_nxt) begin
      w_lock_nxt = 1'b0;
    end
  end

  // Datapath registers: prescaler, tq index, segment lengths, lock, sampled bit and pulses
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_presc  <= 6'd0;
      r_idx    <= 5'd0;
      r_t1_len <= T1_LEN;
      r_t2_len <= T2_LEN;
      r_lock   <= 1'b0;
      r_rx_bit <= 1'b1;
      r_sp     <= 1'b0;
      r_tx     <= 1'b0;
      r_rs     <= 1'b0;
    end else begin
      r_presc  <= w_presc_nxt;
      r_idx    <= w_idx_nxt;
      r_t1_len <= w_enter_sync ? T1_LEN : w_t1_len_eff;
      r_t2_len <= w_enter_sync ? T2_LEN : w_t2_len_eff;
      r_lock   <= w_lock_nxt;
      r_sp     <= w_sp_nxt;
      r_tx     <= w_tx_nxt;
      r_rs     <= w_rs_nxt;
      if (w_sp_nxt) begin
        r_rx_bit <= r_rx_s;
      end
    end
  end

  assign o_rx_bit       = r_rx_bit;
  assign o_sample_point = r_sp;
  assign o_tx_point     = r_tx;
  assign o_resync_pulse = r_rs;

endmodule
